// File: rtl/rs_pkg.sv
// rs_pkg: shared widths and the entry record for the reservation station
package rs_pkg;
    localparam int ROB_TAG_LEN    = 5;
    localparam int RS_NUM_ENTRIES = 4;
    localparam int RS_XLEN        = 32;
    localparam int RS_OP_W        = 8;
    localparam int RS_AGE_W       = $clog2(RS_NUM_ENTRIES);
    typedef struct packed {
        logic                   valid;
        logic [RS_OP_W-1:0]     op;
        logic [ROB_TAG_LEN-1:0] rob_tag;
        logic                   s1_rdy;
        logic [RS_XLEN-1:0]     s1_val;
        logic [ROB_TAG_LEN-1:0] s1_tag;
        logic                   s2_rdy;
        logic [RS_XLEN-1:0]     s2_val;
        logic [ROB_TAG_LEN-1:0] s2_tag;
        logic [RS_AGE_W-1:0]    age;
    } RS_ENTRY;
endpackage

// File: rtl/rs_select.sv
// rs_select: oldest-ready picker; cand_i/age_i per slot in, one-hot gnt_o and valid_o out
module rs_select
    import rs_pkg::*;
#(
    parameter int N  = RS_NUM_ENTRIES,
    parameter int AW = RS_AGE_W
) (
    input  logic [N-1:0]         cand_i,
    input  logic [N-1:0][AW-1:0] age_i,
    output logic [N-1:0]         gnt_o,
    output logic                 valid_o
);
    logic [AW-1:0] best;
    logic [AW-1:0] idx;
    // strict greater-than keeps the lowest index on equal ages
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        best    = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_i[i] && (!valid_o || age_i[i] > best)) begin
                valid_o = 1'b1;
                best    = age_i[i];
                idx     = AW'(i);
            end
        end
        if (valid_o) gnt_o[idx] = 1'b1;
    end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: per-FU station holding dispatched ops until operands arrive via the CDB
//   in : dispatch_* (new op), cdb_* (wakeup broadcast), issue_grant, flush
//   out: full, free_count, insn_ready and issue_* describing the oldest ready entry
module reservation_station
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = RS_NUM_ENTRIES,
    parameter int XLEN        = RS_XLEN,
    parameter int TAG_W       = ROB_TAG_LEN,
    parameter int OP_W        = RS_OP_W
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           flush,
    input  logic                           dispatch_valid,
    input  logic [OP_W-1:0]                dispatch_op,
    input  logic [TAG_W-1:0]               dispatch_rob_tag,
    input  logic                           dispatch_src1_ready,
    input  logic [XLEN-1:0]                dispatch_src1_value,
    input  logic [TAG_W-1:0]               dispatch_src1_tag,
    input  logic                           dispatch_src2_ready,
    input  logic [XLEN-1:0]                dispatch_src2_value,
    input  logic [TAG_W-1:0]               dispatch_src2_tag,
    input  logic                           cdb_valid,
    input  logic [TAG_W-1:0]               cdb_tag,
    input  logic [XLEN-1:0]                cdb_value,
    input  logic                           issue_grant,
    output logic                           full,
    output logic                           insn_ready,
    output logic [TAG_W-1:0]               issue_rob_tag,
    output logic [OP_W-1:0]                issue_op,
    output logic [XLEN-1:0]                issue_src1,
    output logic [XLEN-1:0]                issue_src2,
    output logic [$clog2(NUM_ENTRIES):0]   free_count
);
    localparam int AW = $clog2(NUM_ENTRIES);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] rob_tag;
        logic             s1_rdy;
        logic [XLEN-1:0]  s1_val;
        logic [TAG_W-1:0] s1_tag;
        logic             s2_rdy;
        logic [XLEN-1:0]  s2_val;
        logic [TAG_W-1:0] s2_tag;
        logic [AW-1:0]    age;
    } entry_t;

    entry_t                        ent_q [NUM_ENTRIES];
    entry_t                        ent_d [NUM_ENTRIES];
    logic   [NUM_ENTRIES-1:0]          valid;
    logic   [NUM_ENTRIES-1:0]          cand;
    logic   [NUM_ENTRIES-1:0]          gnt;
    logic   [NUM_ENTRIES-1:0][AW-1:0]  ages;
    logic   [AW-1:0]                   free_idx;
    logic                              any_rdy;
    logic                              do_disp;
    logic                              do_issue;
    logic                              fwd1;
    logic                              fwd2;

    always_comb begin
        free_idx   = '0;
        free_count = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            valid[i]   = ent_q[i].valid;
            cand[i]    = ent_q[i].valid & ent_q[i].s1_rdy & ent_q[i].s2_rdy;
            ages[i]    = ent_q[i].age;
            free_count = free_count + CW'(!ent_q[i].valid);
            if (!ent_q[i].valid) free_idx = AW'(i);
        end
    end

    assign full = &valid;

    rs_select #(.N(NUM_ENTRIES), .AW(AW)) u_sel (
        .cand_i  (cand),
        .age_i   (ages),
        .gnt_o   (gnt),
        .valid_o (any_rdy)
    );

    assign insn_ready = any_rdy;

    always_comb begin
        issue_rob_tag = '0;
        issue_op      = '0;
        issue_src1    = '0;
        issue_src2    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (gnt[i]) begin
                issue_rob_tag = ent_q[i].rob_tag;
                issue_op      = ent_q[i].op;
                issue_src1    = ent_q[i].s1_val;
                issue_src2    = ent_q[i].s2_val;
            end
        end
    end

    // full is registered state, so a same-cycle grant never makes room for a dispatch
    assign do_disp  = dispatch_valid & ~full;
    assign do_issue = issue_grant & any_rdy;
    assign fwd1     = ~dispatch_src1_ready & cdb_valid & (dispatch_src1_tag == cdb_tag);
    assign fwd2     = ~dispatch_src2_ready & cdb_valid & (dispatch_src2_tag == cdb_tag);

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid && cdb_valid) begin
                if (!ent_q[i].s1_rdy && ent_q[i].s1_tag == cdb_tag) begin
                    ent_d[i].s1_rdy = 1'b1;
                    ent_d[i].s1_val = cdb_value;
                end
                if (!ent_q[i].s2_rdy && ent_q[i].s2_tag == cdb_tag) begin
                    ent_d[i].s2_rdy = 1'b1;
                    ent_d[i].s2_val = cdb_value;
                end
            end
            if (do_issue && gnt[i]) begin
                ent_d[i].valid = 1'b0;
                ent_d[i].age   = '0;
            end else if (do_disp && ent_q[i].valid && ent_q[i].age != AW'(NUM_ENTRIES - 1)) begin
                ent_d[i].age = ent_q[i].age + 1'b1;
            end
            // free_idx is chosen from registered valid bits, so a slot freed by grant is never picked
            if (do_disp && free_idx == AW'(i)) begin
                ent_d[i].valid   = 1'b1;
                ent_d[i].op      = dispatch_op;
                ent_d[i].rob_tag = dispatch_rob_tag;
                ent_d[i].s1_rdy  = dispatch_src1_ready | fwd1;
                ent_d[i].s1_val  = fwd1 ? cdb_value : dispatch_src1_value;
                ent_d[i].s1_tag  = dispatch_src1_tag;
                ent_d[i].s2_rdy  = dispatch_src2_ready | fwd2;
                ent_d[i].s2_val  = fwd2 ? cdb_value : dispatch_src2_value;
                ent_d[i].s2_tag  = dispatch_src2_tag;
                ent_d[i].age     = '0;
            end
            if (flush) ent_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
        end
    end
endmodule
